// File: rtl/program_loader.sv
// program_loader
//   Boot-time loader feeding the RV32 core's instruction memory. Accepts a
//   byte stream over valid/ready, assembles little-endian 32-bit words, writes
//   them to consecutive word addresses, then releases the core via core_en.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   en                   global enable; low freezes all state and gates outputs
//   start, len_words     load request and its word count (sampled on start)
//   s_valid/s_data/s_ready  upstream byte stream handshake
//   mem_we/mem_addr/mem_wd  instruction memory write port (word index address)
//   core_en              core enable, high only in DONE
//   busy, done, error    status flags
module program_loader #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_CAPACITY = 10,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len_words,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  core_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int IDX_W = (MEM_CAPACITY > 1) ? $clog2(MEM_CAPACITY) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]      word_idx;
  logic [1:0]            byte_cnt;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wd_q;

  logic len_zero;
  logic len_over;
  logic last_word;

  assign len_zero  = (len_words == '0);
  assign len_over  = (len_words > LEN_WIDTH'(MEM_CAPACITY));
  assign last_word = ((LEN_WIDTH'(word_idx) + LEN_WIDTH'(1)) == len_q);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            if (len_zero) begin
              state_nxt = DONE;
            end else if (len_over) begin
              state_nxt = ERROR;
            end else begin
              state_nxt = LOAD;
            end
          end
        end
        LOAD: begin
          if (s_valid && (byte_cnt == 2'd3)) begin
            state_nxt = WRITE;
          end
        end
        WRITE: begin
          state_nxt = last_word ? DONE : LOAD;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_idx <= '0;
      byte_cnt <= '0;
      len_q    <= '0;
      word_q   <= '0;
      addr_q   <= '0;
      wd_q     <= '0;
    end else if (en) begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start && !len_zero && !len_over) begin
            len_q    <= len_words;
            word_idx <= '0;
            byte_cnt <= '0;
            word_q   <= '0;
          end
        end
        LOAD: begin
          if (s_valid) begin
            word_q[8*byte_cnt +: 8] <= s_data;
            byte_cnt                <= byte_cnt + 2'd1;
          end
        end
        WRITE: begin
          // Capture what was written so mem_addr/mem_wd hold it afterwards.
          addr_q   <= DATA_WIDTH'(word_idx);
          wd_q     <= word_q;
          byte_cnt <= '0;
          // The final word leaves word_idx at its last address so the index
          // stays within MEM_CAPACITY-1; it is cleared on the next start.
          if (!last_word) begin
            word_idx <= word_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode: registered state only, gated by en
  always_comb begin
    s_ready  = 1'b0;
    mem_we   = 1'b0;
    core_en  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    mem_addr = addr_q;
    mem_wd   = wd_q;
    if (state == WRITE) begin
      mem_addr = DATA_WIDTH'(word_idx);
      mem_wd   = word_q;
    end
    if (en) begin
      case (state)
        LOAD: begin
          s_ready = 1'b1;
          busy    = 1'b1;
        end
        WRITE: begin
          mem_we = 1'b1;
          busy   = 1'b1;
        end
        DONE: begin
          core_en = 1'b1;
          done    = 1'b1;
        end
        ERROR: begin
          error = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Directed bench for program_loader. Expected memory writes are queued as
//   stimulus is issued; a negedge monitor pops and compares each mem_we pulse.
//   Status/timing checks are made inline by the stimulus process.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic [15:0] len_words = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, mem_we, core_en, busy, done, error;
  logic [31:0] mem_addr, mem_wd;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_writes = 0;
  int unsigned cyc = 0;
  logic [63:0] exp_q[$];

  program_loader #(
    .DATA_WIDTH  (32),
    .MEM_CAPACITY(10),
    .LEN_WIDTH   (16)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .en       (en),
    .start    (start),
    .len_words(len_words),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .core_en  (core_en),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // {busy, done, error, core_en, s_ready, mem_we}
  function automatic logic [31:0] status();
    return {26'd0, busy, done, error, core_en, s_ready, mem_we};
  endfunction

  localparam logic [31:0] ST_ZERO  = 32'h00;
  localparam logic [31:0] ST_DONE  = 32'h14;
  localparam logic [31:0] ST_ERROR = 32'h08;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rstn && mem_we) begin
      logic [63:0] e;
      n_writes++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write", mem_addr, mem_wd);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", mem_addr, e[63:32]);
        check("wr_data", mem_wd, e[31:0]);
      end
      check("s_ready_in_write", {31'd0, s_ready}, 32'd0);
    end
  end

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // start is sampled on the next rising edge ("edge 0"); returns 1ns after it.
  task automatic pulse_start(input logic [15:0] len);
    start = 1'b1;
    len_words = len;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Offers a byte, returns 1ns after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int unsigned waited = 0;
    s_valid = 1'b1;
    s_data  = b;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      waited++;
      if (waited > 50) begin
        n_cmp++;
        n_bad++;
        $display("FAIL byte_accept_timeout: got no s_ready expected accept of 0x%02h", b);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    if (gap) begin
      s_data = 8'hEE;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    int unsigned w0;
    logic [31:0] w;

    // Reset
    #2;
    check("reset_status", status(), ST_ZERO);
    check("reset_addr", mem_addr, 32'd0);
    check("reset_wd", mem_wd, 32'd0);
    idle(2);
    rstn = 1'b1;
    @(negedge clk);
    check("post_reset_status", status(), ST_ZERO);

    // len_words = 0 -> DONE on the sampling edge, no writes
    @(posedge clk); #1;
    pulse_start(16'd0);
    @(negedge clk);
    check("len0_status", status(), ST_DONE);

    // Two-word load, no gaps, latency check
    idle(1);
    expect_write(32'd0, 32'h00500013);
    expect_write(32'd1, 32'h00100093);
    pulse_start(16'd2);
    c0 = cyc;
    check("load2_core_en_drop", {31'd0, core_en}, 32'd0);
    send_word(32'h00500013, 1'b0);
    send_word(32'h00100093, 1'b0);
    check("load2_last_byte_edge", cyc - c0, 32'd9);
    @(negedge clk);
    check("load2_edge9_status", status(), 32'h21);
    @(posedge clk);
    @(negedge clk);
    check("load2_edge10_status", status(), ST_DONE);
    check("load2_hold_addr", mem_addr, 32'd1);
    check("load2_hold_wd", mem_wd, 32'h00100093);

    // Same load with s_valid toggling 1-0-1
    idle(1);
    expect_write(32'd0, 32'h00500013);
    expect_write(32'd1, 32'h00100093);
    pulse_start(16'd2);
    send_word(32'h00500013, 1'b1);
    send_word(32'h00100093, 1'b1);
    idle(2);
    check("gaps_status", status(), ST_DONE);

    // Oversize length from DONE -> ERROR, core_en drops
    pulse_start(16'd11);
    @(negedge clk);
    check("len11_status", status(), ST_ERROR);
    idle(3);
    check("len11_stays_error", status(), ST_ERROR);

    // Full capacity from ERROR
    w0 = n_writes;
    for (int i = 0; i < 10; i++) begin
      w = {8'hA0 + 8'(i), 8'h5C, 8'h3E ^ 8'(i), 8'h10 + 8'(i)};
      expect_write(32'(i), w);
    end
    pulse_start(16'd10);
    for (int i = 0; i < 10; i++) begin
      w = {8'hA0 + 8'(i), 8'h5C, 8'h3E ^ 8'(i), 8'h10 + 8'(i)};
      send_word(w, 1'b0);
    end
    idle(2);
    check("len10_write_count", n_writes - w0, 32'd10);
    check("len10_status", status(), ST_DONE);
    check("len10_hold_addr", mem_addr, 32'd9);

    // Reset after 6 bytes of a 2-word load
    expect_write(32'd0, 32'h11223344);
    pulse_start(16'd2);
    send_word(32'h11223344, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    check("midreset_status", status(), ST_ZERO);
    check("midreset_addr", mem_addr, 32'd0);
    check("midreset_wd", mem_wd, 32'd0);
    idle(2);
    rstn = 1'b1;
    @(negedge clk);
    check("midreset_release_status", status(), ST_ZERO);
    @(posedge clk); #1;
    expect_write(32'd0, 32'hCAFEF00D);
    expect_write(32'd1, 32'h0BADBEEF);
    pulse_start(16'd2);
    send_word(32'hCAFEF00D, 1'b0);
    send_word(32'h0BADBEEF, 1'b0);
    idle(2);
    check("restart_status", status(), ST_DONE);

    // Enable freeze in WRITE; start during LOAD ignored
    expect_write(32'd0, 32'h87654321);
    pulse_start(16'd1);
    send_byte(8'h21, 1'b0);
    send_byte(8'h43, 1'b0);
    start = 1'b1;
    len_words = 16'd0;
    send_byte(8'h65, 1'b0);
    start = 1'b0;
    send_byte(8'h87, 1'b0);
    en = 1'b0;
    w0 = n_writes;
    repeat (3) begin
      @(negedge clk);
      check("freeze_status", status(), ST_ZERO);
    end
    @(posedge clk); #1;
    check("freeze_no_write", n_writes - w0, 32'd0);
    en = 1'b1;
    @(negedge clk);
    check("freeze_resume_we", {31'd0, mem_we}, 32'd1);
    idle(3);
    check("freeze_write_count", n_writes - w0, 32'd1);
    check("freeze_done_status", status(), ST_DONE);

    // en low in DONE gates core_en
    en = 1'b0;
    @(negedge clk);
    check("en_low_done_status", status(), ST_ZERO);
    @(posedge clk); #1;
    en = 1'b1;
    @(negedge clk);
    check("en_high_done_status", status(), ST_DONE);

    // Drain scoreboard
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
